// File: rtl/chi_inv_seq_if.sv
// chi_inv_seq_if -- handshake bundle for the sequential chi-inverse block.
//   master : drives in_valid/state_in/out_ready, observes in_ready/out_valid/state_out/err
//   slave  : the chi_inv_seq side of the same signals
// State arrays are indexed [x][y][z], Z bits per lane.
interface chi_inv_seq_if #(parameter int Z = 64);
   logic                      in_valid;
   logic                      in_ready;
   logic [4:0][4:0][Z-1:0]    state_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [4:0][4:0][Z-1:0]    state_out;
   logic                      err;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_out, err
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_out, err
   );
endinterface

// File: rtl/chi_inv_seq.sv
// chi_inv_seq -- sequential inverse of the Keccak chi step.
// Accepts a 5x5xZ state, inverts one y-plane per cycle through a 32-entry
// row table, and presents the result until the downstream handshake.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : chi_inv_seq_if.slave (in_valid/in_ready/state_in,
//            out_valid/out_ready/state_out, err)
// Optional feature macro: CHI_INV_SELFCHECK_EN -- re-applies forward chi to
// each freshly written output plane and sets sticky err on any mismatch.
// Without the macro, err is tied low and no forward-chi datapath exists.
module chi_inv_seq #(
   parameter int Z = 64
) (
   input logic          clk,
   input logic          rst_n,
   chi_inv_seq_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // Forward chi on one 5-bit row, bit x = lane x.
   function automatic logic [4:0] chi5(input logic [4:0] a);
      logic [4:0] b;
      b = '0;
      for (int x = 0; x < 5; x++)
         b[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
      return b;
   endfunction

   // Inverse table: the row chi map is a bijection, so scattering the
   // forward map fills every entry exactly once.
   function automatic logic [31:0][4:0] build_inv();
      logic [31:0][4:0] t;
      t = '0;
      for (int i = 0; i < 32; i++)
         t[chi5(5'(i))] = 5'(i);
      return t;
   endfunction

   localparam logic [31:0][4:0] CHI_INV = build_inv();

   state_t                 state_q, state_d;
   logic [4:0][4:0][Z-1:0] in_q;
   logic [4:0][4:0][Z-1:0] out_q, out_d;
   logic [2:0]             py_q;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   cap_en, run_en;
   logic [4:0]             row, inv;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Handshakes use the registered in_ready/out_valid so nothing is accepted
   // in the first cycle after reset, when in_ready is still low.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid && in_ready_q)    state_d = S_RUN;
         S_RUN:  if (py_q == 3'd4)                  state_d = S_DONE;
         S_DONE: if (out_valid_q && bus.out_ready)  state_d = S_IDLE;
         default:                                   state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Handshake outputs are computed from the next state and registered,
   // so no input reaches an output port combinationally.
   always_comb begin
      cap_en      = (state_q == S_IDLE) && bus.in_valid && in_ready_q;
      run_en      = (state_q == S_RUN);
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // Plane py of the output register is replaced by the inverted rows.
   always_comb begin
      out_d = out_q;
      row   = '0;
      inv   = '0;
      for (int z = 0; z < Z; z++) begin
         for (int x = 0; x < 5; x++)
            row[x] = in_q[x][py_q][z];
         inv = CHI_INV[row];
         for (int x = 0; x < 5; x++)
            out_d[x][py_q][z] = inv[x];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_q        <= '0;
         out_q       <= '0;
         py_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         if (cap_en) begin
            in_q <= bus.state_in;
            py_q <= '0;
         end else if (run_en) begin
            out_q <= out_d;
            // saturate at the last plane; cleared again on the next accept
            if (py_q != 3'd4) py_q <= py_q + 3'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.state_out = out_q;

`ifdef CHI_INV_SELFCHECK_EN
   // The check runs one cycle behind the write and reads the output register
   // itself, so corruption of stored result bits is caught, not only table
   // errors. The last plane is checked in the first DONE cycle.
   logic       chk_vld_q;
   logic [2:0] chk_py_q;
   logic       err_q;
   logic       mis;
   logic [4:0] crow, irow;

   always_comb begin
      mis  = 1'b0;
      crow = '0;
      irow = '0;
      for (int z = 0; z < Z; z++) begin
         for (int x = 0; x < 5; x++) begin
            crow[x] = out_q[x][chk_py_q][z];
            irow[x] = in_q[x][chk_py_q][z];
         end
         if (chi5(crow) != irow) mis = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chk_vld_q <= 1'b0;
         chk_py_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         chk_vld_q <= run_en;
         chk_py_q  <= py_q;
         if (chk_vld_q && mis) err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule
